// File: rtl/rgb_hue_fader.sv
// rgb_hue_fader: walks the hue wheel RED->YELLOW->GREEN->CYAN->BLUE->MAGENTA
// either as hard colour steps or as a PWM cross-fade, driving active-low LED pins.
// Optional build macro GAMMA_EN: squares the fade ramp for a perceptually
// smoother fade; undefined gives a linear ramp with no multiplier.
//
// seg | meaning
// ----+---------------------------------------------
//  0  | RED      (fade: G rises)
//  1  | YELLOW   (fade: R falls)
//  2  | GREEN    (fade: B rises)
//  3  | CYAN     (fade: G falls)
//  4  | BLUE     (fade: R rises)
//  5  | MAGENTA  (fade: B falls)
// 6-7 | unreachable, forced back to RED

module rgb_hue_fader #(
  parameter int STEP_INTERVAL = 2000000,
  parameter int PWM_BITS      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       dir,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] seg_o,
  output logic       wrap_o
);

  localparam int TW = $clog2(STEP_INTERVAL);

  localparam logic [TW-1:0]       TC_LAST = TW'(STEP_INTERVAL - 1);
  localparam logic [TW-1:0]       TC_ONE  = TW'(1);
  localparam logic [PWM_BITS-1:0] MAX     = '1;
  localparam logic [PWM_BITS-1:0] P_ZERO  = '0;
  localparam logic [PWM_BITS-1:0] P_ONE   = PWM_BITS'(1);

  localparam logic [2:0] SEG_RED = 3'd0;
  localparam logic [2:0] SEG_YEL = 3'd1;
  localparam logic [2:0] SEG_GRN = 3'd2;
  localparam logic [2:0] SEG_CYN = 3'd3;
  localparam logic [2:0] SEG_BLU = 3'd4;
  localparam logic [2:0] SEG_MAG = 3'd5;

  logic [2:0]          seg_q, seg_d;
  logic [PWM_BITS-1:0] r_q, r_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                mode_q;
  logic                wrap_q, wrap_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;

  logic                tick;
  logic                mode_chg;
  logic [2:0]          seg_inc, seg_dec;

  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0] r_inv;
  logic [PWM_BITS-1:0] g_up, g_down;
  logic                lit_r, lit_g, lit_b;

  // Ramp shaping applied to every fading channel.
  function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] x);
`ifdef GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, x} * {{PWM_BITS{1'b0}}, x};
    // Full-scale stays full-scale so the end of a ramp is truly solid.
    if (x == MAX) return MAX;
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return x;
`endif
  endfunction

  assign tick     = en && (tick_cnt_q == TC_LAST);
  assign mode_chg = (mode != mode_q);
  assign seg_inc  = (seg_q == SEG_MAG) ? SEG_RED : seg_q + 3'd1;
  assign seg_dec  = (seg_q == SEG_RED) ? SEG_MAG : seg_q - 3'd1;

  // State register: segment, ramp, tick timer, mode history, wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= SEG_RED;
      r_q        <= '0;
      tick_cnt_q <= '0;
      mode_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      r_q        <= r_d;
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode;
      wrap_q     <= wrap_d;
    end
  end

  // Next state: a mode change restarts the ramp and timer and beats any tick.
  always_comb begin
    seg_d      = seg_q;
    r_d        = r_q;
    tick_cnt_d = tick_cnt_q;
    if (seg_q > SEG_MAG) begin
      seg_d = SEG_RED;
    end
    if (mode_chg) begin
      tick_cnt_d = '0;
      r_d        = '0;
    end else if (en) begin
      if (tick) begin
        tick_cnt_d = '0;
        if (seg_q <= SEG_MAG) begin
          if (!mode) begin
            r_d   = '0;
            seg_d = dir ? seg_dec : seg_inc;
          end else if (!dir) begin
            if (r_q == MAX) begin
              r_d   = '0;
              seg_d = seg_inc;
            end else begin
              r_d = r_q + P_ONE;
            end
          end else begin
            if (r_q == P_ZERO) begin
              r_d   = MAX;
              seg_d = seg_dec;
            end else begin
              r_d = r_q - P_ONE;
            end
          end
        end
      end else begin
        tick_cnt_d = tick_cnt_q + TC_ONE;
      end
    end
    wrap_d = ((seg_q == SEG_MAG) && (seg_d == SEG_RED)) ||
             ((seg_q == SEG_RED) && (seg_d == SEG_MAG));
  end

  assign r_inv  = MAX - r_q;
  assign g_up   = shape(r_q);
  assign g_down = shape(r_inv);

  // Output decode: per-channel duty from segment and ramp, then PWM compare.
  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    if (!mode_q) begin
      unique case (seg_q)
        SEG_RED: duty_r = MAX;
        SEG_YEL: begin duty_r = MAX; duty_g = MAX; end
        SEG_GRN: duty_g = MAX;
        SEG_CYN: begin duty_g = MAX; duty_b = MAX; end
        SEG_BLU: duty_b = MAX;
        SEG_MAG: begin duty_r = MAX; duty_b = MAX; end
        default: ;
      endcase
    end else begin
      unique case (seg_q)
        SEG_RED: begin duty_r = MAX;    duty_g = g_up;   end
        SEG_YEL: begin duty_r = g_down; duty_g = MAX;    end
        SEG_GRN: begin duty_g = MAX;    duty_b = g_up;   end
        SEG_CYN: begin duty_g = g_down; duty_b = MAX;    end
        SEG_BLU: begin duty_r = g_up;   duty_b = MAX;    end
        SEG_MAG: begin duty_r = MAX;    duty_b = g_down; end
        default: ;
      endcase
    end
    lit_r = (duty_r == MAX) || (pwm_cnt_q < duty_r);
    lit_g = (duty_g == MAX) || (pwm_cnt_q < duty_g);
    lit_b = (duty_b == MAX) || (pwm_cnt_q < duty_b);
  end

  // Free-running PWM counter and registered active-low pins (dark in reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      RGB_R     <= 1'b1;
      RGB_G     <= 1'b1;
      RGB_B     <= 1'b1;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + P_ONE;
      RGB_R     <= ~lit_r;
      RGB_G     <= ~lit_g;
      RGB_B     <= ~lit_b;
    end
  end

  assign seg_o  = seg_q;
  assign wrap_o = wrap_q;

endmodule

// File: doc/rgb_hue_fader.md
Name: rgb_hue_fader

Overview:
- Parametrised successor to the discrete six-colour RGB cycler.
- Walks the hue wheel RED→YELLOW→GREEN→CYAN→BLUE→MAGENTA→RED, either as hard colour steps or as a smooth PWM cross-fade.
- Supports run/pause, direction control and a wrap indication.
- Drives the active-low on-board RGB LED pins directly; sits at top level beside the clock.

Parameters:
- STEP_INTERVAL, 2000000: clocks per tick (one ramp increment in fade mode, one colour in step mode); must be >= 2.
- PWM_BITS, 8: PWM counter and duty width; MAX = 2^PWM_BITS-1; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  1 = advance; 0 = freeze colour (PWM keeps running).
- mode  in  1  0 = step mode, 1 = fade mode.
- dir  in  1  0 = forward hue order, 1 = reverse.
- RGB_R  out  1  red LED, active-low (0 = lit).
- RGB_G  out  1  green LED, active-low.
- RGB_B  out  1  blue LED, active-low.
- seg_o  out  3  current segment: 0 RED, 1 YELLOW, 2 GREEN, 3 CYAN, 4 BLUE, 5 MAGENTA.
- wrap_o  out  1  one-cycle pulse on wheel wrap.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset state: seg=0, ramp r=0, tick_cnt=0, pwm_cnt=0, mode_q=mode-at-release tracked from 0. Outputs RGB_R/G/B=1 (all dark), wrap_o=0, seg_o=0.
- Tick counter: tick_cnt is $clog2(STEP_INTERVAL) bits. It increments while en=1. tick is high when tick_cnt==STEP_INTERVAL-1; on that edge tick_cnt wraps to 0. It holds while en=0.
- PWM: pwm_cnt is a free-running PWM_BITS counter and never stops, including when en=0. For channel duty d, the channel is lit when d==MAX or pwm_cnt<d. d=0 means always dark.
- Output timing: outputs are registered, so pin level = inverted lit, one clock after the state/pwm_cnt that produced it.
- Step mode (mode=0): on each tick, seg advances +1 (dir=0) or -1 (dir=1), modulo 6. r is held at 0. Duties are MAX or 0 per the segment's pure colour:
  - RED: R
  - YELLOW: R+G
  - GREEN: G
  - CYAN: G+B
  - BLUE: B
  - MAGENTA: R+B
- Fade mode (mode=0 for step, mode=1 for fade; this item is mode=1), dir=0:
  - On each tick, r increments.
  - A tick with r==MAX sets r=0 and seg+1 instead.
- Fade mode, dir=1:
  - On each tick, r decrements.
  - A tick with r==0 sets r=MAX and seg-1 instead.
- Fade duties (g(x)=x unless GAMMA_EN):
  - RED: R=MAX, G=g(r), B=0.
  - YELLOW: R=g(MAX-r), G=MAX, B=0.
  - GREEN: R=0, G=MAX, B=g(r).
  - CYAN: R=0, G=g(MAX-r), B=MAX.
  - BLUE: R=g(r), G=0, B=MAX.
  - MAGENTA: R=MAX, G=0, B=g(MAX-r).
- Wrap: wrap_o=1 for exactly the cycle after a seg transition 5→0 (dir=0) or 0→5 (dir=1); 0 otherwise.
- Mode change: any cycle where mode != mode_q clears tick_cnt and r to 0 and holds seg. This takes priority over a coincident tick.
- Direction change: takes effect at the next tick. No state is cleared.
- seg_o: always equals the registered seg. Values 6 and 7 are unreachable; if seen, force seg=0 next cycle.
- Mid-operation reset: rst asserted at any time immediately darkens all LEDs and returns every register to its reset value.

Optional Feature:
- Macro: GAMMA_EN.
- Defined: g(x) = (x*x)>>PWM_BITS for x<MAX, and g(MAX)=MAX. The square uses a 2*PWM_BITS-bit product, giving a perceptually smoother fade.
- Undefined: g(x)=x, with no multiplier synthesised.
- Step mode is unaffected either way.

Test Plan:
1. Reset and step (PWM_BITS=2, STEP_INTERVAL=4, mode=0, dir=0, en=1): rst high → RGB=111, seg_o=0. After release → RGB_R=0, G=1, B=1 from cycle 1. seg_o=1 after 4th edge, then RGB=001.
2. Forward wrap, step mode: 6 ticks (24 clocks) → seg_o sequence 1,2,3,4,5,0. wrap_o=1 for exactly one clock at the 5→0 transition. Reverse run from reset with dir=1 → seg_o=5 after first tick, with a wrap_o pulse.
3. Fade PWM (PWM_BITS=2, STEP_INTERVAL=4, mode=1): in RED with r=1, RGB_G low 1 of every 4 clocks. With r=2, low 2 of 4. RGB_R constantly 0, RGB_B constantly 1. After r=3 and the next tick → seg_o=1, r=0, RGB_R constantly low.
4. Pause: en=0 for 20 clocks mid-fade → seg_o and r unchanged, PWM pattern still toggling. en=1 → tick resumes from the held tick_cnt.
5. Mode toggle at r=2 in GREEN → r=0, tick_cnt=0, seg_o stays 2, even when the toggle coincides with a tick.
6. GAMMA_EN with PWM_BITS=4: r=8 → green duty 4 (lit 4 of 16 clocks); r=15 → duty 15 (constantly lit).
